pipe_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It combines the load-use stall from the hazard unit, the taken-branch/jump redirect from EX, and the data-memory ready handshake from MEM. It also accepts an external halt request. From these it produces per-stage stall and flush enables. It owns an FSM for memory-wait timeout and pipeline drain/halt.

---
 rtl/pipe_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait timeout, drain and halt.
// Define PIPE_CTRL_PERF_EN to add the stall/flush/memory-wait performance counters.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_lu,
  input  logic PCSrcE,
  input  logic dmem_req_M,
  input  logic dmem_ready,
  input  logic halt_req,
  output logic StallF,
  output logic StallD,
  output logic StallE,
  output logic StallM,
  output logic FlushD,
  output logic FlushE,
  output logic FlushW,
  output logic halted,
  output logic mem_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_memwait_cnt
`endif
);

  // state      | meaning
  // S_RUN      | normal issue; hazards resolved combinationally
  // S_MEM_WAIT | data memory not ready; pipeline frozen, timeout running
  // S_DRAIN    | no new fetches; bubbles pushed until the pipe is empty
  // S_HALTED   | pipeline empty and frozen until halt_req drops
  // S_ERROR    | memory timeout; frozen until reset
  typedef enum logic [2:0] {S_RUN, S_MEM_WAIT, S_DRAIN, S_HALTED, S_ERROR} state_t;

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [WW-1:0] WAIT_FULL  = WW'(MEM_TIMEOUT);
  localparam logic [WW-1:0] WAIT_FIRST = WW'(MEM_TIMEOUT - 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  if (MEM_TIMEOUT < 1 || DRAIN_CYCLES < 1 || CNT_W < 1) begin : g_param_check
    $error("pipe_ctrl: MEM_TIMEOUT, DRAIN_CYCLES and CNT_W must all be >= 1");
  end

  state_t        state;
  logic [WW-1:0] wait_left;   // frozen cycles remaining before a timeout
  logic [DW-1:0] drain_left;  // non-frozen drain cycles remaining before HALTED
  logic          freeze;
  logic          frz_out;
  logic          hold_all;
  logic          redirect;

  assign freeze = dmem_req_M & ~dmem_ready;

  always_comb begin
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    StallM   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushW   = 1'b0;
    halted   = 1'b0;
    mem_err  = 1'b0;
    frz_out  = 1'b0;
    hold_all = 1'b0;
    redirect = 1'b0;
    if (rst) begin
      case (state)
        S_RUN, S_MEM_WAIT: begin
          // MEM_WAIT keys on ready alone: the stalled access is still in M
          if ((state == S_RUN) ? freeze : ~dmem_ready) begin
            frz_out = 1'b1;
          end else if (PCSrcE) begin
            FlushD   = 1'b1;
            FlushE   = 1'b1;
            redirect = 1'b1;
          end else if (stall_lu) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
        end
        S_DRAIN: begin
          if (freeze) begin
            frz_out = 1'b1;
          end else begin
            StallF   = ~PCSrcE;
            FlushD   = 1'b1;
            FlushE   = PCSrcE;
            redirect = PCSrcE;
          end
        end
        S_HALTED: begin
          halted   = 1'b1;
          hold_all = 1'b1;
        end
        S_ERROR: begin
          mem_err  = 1'b1;
          hold_all = 1'b1;
        end
        default: hold_all = 1'b1;
      endcase
      if (frz_out || hold_all) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
        FlushD = 1'b0;
        FlushE = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_RUN;
      wait_left  <= WAIT_FULL;
      drain_left <= DRAIN_LOAD;
    end else begin
      case (state)
        S_RUN: begin
          if (freeze) begin
            state     <= S_MEM_WAIT;
            wait_left <= WAIT_FIRST;
          end else if (halt_req) begin
            state      <= S_DRAIN;
            drain_left <= DRAIN_LOAD;
          end
        end
        S_MEM_WAIT: begin
          if (!dmem_ready) begin
            if (wait_left <= WW'(1)) state <= S_ERROR;
            else wait_left <= wait_left - WW'(1);
          end else begin
            wait_left <= WAIT_FULL;
            if (halt_req) begin
              state      <= S_DRAIN;
              drain_left <= DRAIN_LOAD;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_DRAIN: begin
          if (freeze) begin
            // a dropped halt while frozen still has to finish the memory wait
            if (wait_left <= WW'(1)) state <= S_ERROR;
            else begin
              wait_left <= wait_left - WW'(1);
              if (!halt_req) state <= S_MEM_WAIT;
            end
          end else begin
            wait_left <= WAIT_FULL;
            if (!halt_req) state <= S_RUN;
            else if (drain_left == '0) state <= S_HALTED;
            else drain_left <= drain_left - DW'(1);
          end
        end
        S_HALTED: if (!halt_req) state <= S_RUN;
        S_ERROR: state <= S_ERROR;
        default: state <= S_ERROR;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt   <= '0;
      perf_flush_cnt   <= '0;
      perf_memwait_cnt <= '0;
    end else begin
      if (StallF && state != S_HALTED && state != S_ERROR)
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      if (redirect) perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
      if (frz_out) perf_memwait_cnt <= perf_memwait_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed sequences with literal expectations plus randomized
// stimulus, all compared against a behavioural model of the sequencer every cycle.
module tb_pipe_ctrl;
  localparam int TO = 4;
  localparam int DC = 4;

  // output vector order: StallF StallD StallE StallM FlushD FlushE FlushW halted mem_err
  localparam logic [8:0] ZERO = 9'b000000000;
  localparam logic [8:0] LU   = 9'b110001000;
  localparam logic [8:0] BR   = 9'b000011000;
  localparam logic [8:0] FRZ  = 9'b111100100;
  localparam logic [8:0] DRN  = 9'b100010000;
  localparam logic [8:0] HLT  = 9'b111100110;
  localparam logic [8:0] ERR  = 9'b111100101;

  localparam int M_RUN = 0, M_WAIT = 1, M_DRAIN = 2, M_HALT = 3, M_ERR = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stall_lu = 1'b0, PCSrcE = 1'b0, dmem_req_M = 1'b0, dmem_ready = 1'b1, halt_req = 1'b0;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, halted, mem_err;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_memwait_cnt;
`endif

  pipe_ctrl #(.MEM_TIMEOUT(TO), .DRAIN_CYCLES(DC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall_lu(stall_lu), .PCSrcE(PCSrcE),
    .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready), .halt_req(halt_req),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .halted(halted), .mem_err(mem_err)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_memwait_cnt(perf_memwait_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [8:0] dut_vec;
  assign dut_vec = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, halted, mem_err};

  // behavioural model: mode plus the consecutive-wait and drain progress counts
  int mode = M_RUN;
  int wcnt = 0;
  int dcnt = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode <= M_RUN;
      wcnt <= 0;
      dcnt <= 0;
    end else begin
      case (mode)
        M_RUN:
          if (dmem_req_M && !dmem_ready) begin
            mode <= M_WAIT; wcnt <= 1;
          end else if (halt_req) begin
            mode <= M_DRAIN; dcnt <= 0;
          end
        M_WAIT:
          if (!dmem_ready) begin
            wcnt <= wcnt + 1;
            if (wcnt + 1 >= TO) mode <= M_ERR;
          end else begin
            wcnt <= 0;
            dcnt <= 0;
            mode <= halt_req ? M_DRAIN : M_RUN;
          end
        M_DRAIN:
          if (dmem_req_M && !dmem_ready) begin
            wcnt <= wcnt + 1;
            if (wcnt + 1 >= TO) mode <= M_ERR;
            else if (!halt_req) mode <= M_WAIT;
          end else begin
            wcnt <= 0;
            if (!halt_req) mode <= M_RUN;
            else if (dcnt == DC - 1) mode <= M_HALT;
            else dcnt <= dcnt + 1;
          end
        M_HALT: if (!halt_req) mode <= M_RUN;
        default: mode <= M_ERR;
      endcase
    end
  end

  function automatic logic [8:0] model_out(int m, logic r, logic lu, logic br,
                                           logic req, logic rdy);
    if (!r) return ZERO;
    case (m)
      M_RUN:   return (req && !rdy) ? FRZ : br ? BR : lu ? LU : ZERO;
      M_WAIT:  return (!rdy) ? FRZ : br ? BR : lu ? LU : ZERO;
      M_DRAIN: return (req && !rdy) ? FRZ : br ? BR : DRN;
      M_HALT:  return HLT;
      default: return ERR;
    endcase
  endfunction

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  logic chk_en = 1'b1;
  logic lit_en = 1'b0;
  logic [8:0] lit_exp = ZERO;
  string lit_name = "";

  always @(negedge clk) begin
    logic [8:0] exp_v;
    cyc++;
    exp_v = model_out(mode, rst, stall_lu, PCSrcE, dmem_req_M, dmem_ready);
    if (chk_en) begin
      n_checks++;
      if (dut_vec !== exp_v) begin
        n_err++;
        $display("FAIL model cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_v);
      end
    end
    if (lit_en) begin
      n_checks++;
      if (dut_vec !== lit_exp) begin
        n_err++;
        $display("FAIL %s cyc=%0d got=%b exp=%b", lit_name, cyc, dut_vec, lit_exp);
      end
    end
  end

  task automatic step(input logic r, input logic lu, input logic br, input logic req,
                      input logic rdy, input logic hlt, input logic le,
                      input logic [8:0] ev, input string nm);
    @(posedge clk);
    #1;
    rst = r; stall_lu = lu; PCSrcE = br; dmem_req_M = req; dmem_ready = rdy; halt_req = hlt;
    lit_en = le; lit_exp = ev; lit_name = nm;
  endtask

  initial begin
    logic h;
    // reset dominates every input
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 1, 1, ZERO, "rst_hold");
    step(1, 0, 0, 0, 1, 0, 1, ZERO, "rst_release");
    // RUN priority
    step(1, 1, 0, 0, 1, 0, 1, LU,   "load_use");
    step(1, 0, 0, 0, 1, 0, 1, ZERO, "load_use_off");
    step(1, 1, 1, 0, 1, 0, 1, BR,   "branch_over_lu");
    step(1, 0, 0, 0, 1, 0, 1, ZERO, "idle");
    // memory wait that completes
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0, 1, FRZ, "mem_wait");
    step(1, 0, 0, 1, 1, 0, 1, ZERO, "mem_ready");
    step(1, 0, 1, 1, 0, 0, 1, FRZ,  "freeze_over_branch");
    step(1, 0, 1, 1, 1, 0, 1, BR,   "branch_after_wait");
    step(1, 0, 0, 0, 1, 0, 1, ZERO, "after_mem");
    // timeout into sticky error
    for (int i = 0; i < TO; i++) step(1, 0, 0, 1, 0, 0, 1, FRZ, "timeout_wait");
    step(1, 0, 0, 0, 1, 0, 1, ERR,  "error_on_ready");
    step(1, 1, 1, 0, 1, 1, 1, ERR,  "error_sticky");
    step(0, 0, 0, 0, 1, 0, 1, ZERO, "error_reset");
    step(1, 0, 0, 0, 1, 0, 1, ZERO, "error_cleared");
    // drain and halt
    step(1, 0, 0, 0, 1, 1, 1, ZERO, "halt_req_run");
    step(1, 0, 0, 0, 1, 1, 1, DRN,  "drain1");
    step(1, 0, 1, 0, 1, 1, 1, BR,   "drain2_branch");
    step(1, 1, 0, 0, 1, 1, 1, DRN,  "drain3_lu_ignored");
    step(1, 0, 0, 0, 1, 1, 1, DRN,  "drain4");
    step(1, 0, 0, 0, 1, 1, 1, HLT,  "halted");
    step(1, 0, 0, 0, 1, 1, 1, HLT,  "halted_hold");
    step(1, 0, 0, 0, 1, 0, 1, HLT,  "halt_drop");
    step(1, 0, 0, 0, 1, 0, 1, ZERO, "resumed");
    // freeze during drain delays the halt by two cycles
    step(1, 0, 0, 0, 1, 1, 1, ZERO, "halt_req_run2");
    step(1, 0, 0, 1, 0, 1, 1, FRZ,  "drain_freeze1");
    step(1, 0, 0, 1, 0, 1, 1, FRZ,  "drain_freeze2");
    for (int i = 0; i < DC; i++) step(1, 0, 0, 0, 1, 1, 1, DRN, "drain_after_freeze");
    step(1, 0, 0, 0, 1, 1, 1, HLT,  "halted_late");
    step(1, 0, 0, 0, 1, 0, 1, HLT,  "halt_drop2");
    step(1, 0, 0, 0, 1, 0, 1, ZERO, "resumed2");
    // halt dropped mid-drain, then reset mid-drain
    step(1, 0, 0, 0, 1, 1, 1, ZERO, "halt_req_run3");
    step(1, 0, 0, 0, 1, 1, 1, DRN,  "drain_a");
    step(1, 0, 0, 0, 1, 0, 1, DRN,  "drain_drop");
    step(1, 1, 0, 0, 1, 0, 1, LU,   "back_to_run");
    step(1, 0, 0, 0, 1, 1, 1, ZERO, "halt_req_run4");
    step(1, 0, 0, 0, 1, 1, 1, DRN,  "drain_b");
    step(0, 0, 0, 0, 1, 1, 1, ZERO, "reset_mid_drain");
    step(1, 1, 0, 0, 1, 0, 1, LU,   "run_after_reset");
    // randomized phase, model comparison only
    h = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) h = ~h;
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) != 0), h, 0, ZERO, "");
    end
    step(1, 0, 0, 0, 1, 0, 0, ZERO, "");
    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
